// File: rtl/logic_unit_seq.sv
// Sequential logic unit: 8 bitwise/rotate operations with valid/ready handshake on both sides.
// Optional accumulator feedback enabled by defining LOGIC_UNIT_ACC_EN.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LOGIC_UNIT_ACC_EN
  input  logic             acc_sel,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    HOLD
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] bw_res;

  assign k = B[CW-1:0];

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      acc <= Out;
    end
  end

  assign op_a = acc_sel ? acc : A;
`else
  assign op_a = A;
`endif

  // Rotate loads the unrotated operand; the ROT state performs one step per cycle.
  always_comb begin
    bw_res = '0;
    unique case (S)
      3'b000: bw_res = op_a & B;
      3'b001: bw_res = op_a | B;
      3'b010: bw_res = op_a ^ B;
      3'b011: bw_res = ~op_a;
      3'b100: bw_res = ~(op_a & B);
      3'b101: bw_res = ~(op_a | B);
      3'b110: bw_res = ~(op_a ^ B);
      3'b111: bw_res = op_a;
      default: bw_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = (S == 3'b111 && k != '0) ? ROT : HOLD;
        end
      end
      ROT: begin
        if (cnt <= CW'(1)) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it stays low while reset is held.
  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == HOLD);
    Zero      = (Out == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            Out <= bw_res;
            cnt <= (S == 3'b111) ? k : '0;
          end
        end
        ROT: begin
          Out <= {Out[WIDTH-2:0], Out[WIDTH-1]};
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq (WIDTH=4): directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_logic_unit_seq;

  localparam int W = 4;
`ifdef LOGIC_UNIT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   S;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic         Zero;
`ifdef LOGIC_UNIT_ACC_EN
  logic         acc_sel;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] acc_m = '0;

  logic_unit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LOGIC_UNIT_ACC_EN
    .acc_sel   (acc_sel),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] v, input int n);
    int m;
    m = n % W;
    if (m == 0) return v;
    return (v << m) | (v >> (W - m));
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] s);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return ref_rotl(a, int'(b) % W);
    endcase
  endfunction

  task automatic noise();
    in_valid = 1'($urandom);
    A = W'($urandom);
    B = W'($urandom);
    S = 3'($urandom);
`ifdef LOGIC_UNIT_ACC_EN
    acc_sel = 1'($urandom);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                        input int hold, input bit sel);
    logic [W-1:0] opa;
    logic [W-1:0] res;
    int k;
    int lat;
    int n;
    opa = (ACC && sel) ? acc_m : a;
    res = ref_op(opa, b, s);
    k   = int'(b) % W;
    lat = (s == 3'd7 && k != 0) ? k + 1 : 1;
    in_valid = 1'b1;
    A = a;
    B = b;
    S = s;
`ifdef LOGIC_UNIT_ACC_EN
    acc_sel = sel;
`endif
    chk("ready_idle", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n = 1;
    noise();
    while (!out_valid && n < 64) begin
      if (s == 3'd7) chk("rot_step", Out, ref_rotl(opa, n - 1));
      chk("ready_busy", in_ready, 1'b0);
      @(negedge clk);
      n++;
      noise();
    end
    chk("latency", n, lat);
    chk("out", Out, res);
    chk("zero", Zero, res == '0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      noise();
      chk("hold_out", Out, res);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    acc_m = res;
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_out", Out, res);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    S = '0;
`ifdef LOGIC_UNIT_ACC_EN
    acc_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out", Out, 4'b0000);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);

    run_op(4'b1100, 4'b1010, 3'd0, 0, 1'b0);
    run_op(4'b1011, 4'b1011, 3'd2, 0, 1'b0);
    run_op(4'b0101, 4'b1111, 3'd3, 0, 1'b0);
    run_op(4'b0001, 4'b0011, 3'd7, 0, 1'b0);
    run_op(4'b0001, 4'b0100, 3'd7, 0, 1'b0);
    run_op(4'b0110, 4'b0110, 3'd0, 5, 1'b0);
    run_op(4'b0101, 4'b0011, 3'd4, 1, 1'b0);
    run_op(4'b0101, 4'b0011, 3'd5, 0, 1'b0);
    run_op(4'b0101, 4'b0011, 3'd6, 2, 1'b0);
    run_op(4'b1000, 4'b0001, 3'd7, 0, 1'b0);

    // Reset in the middle of a rotation.
    in_valid = 1'b1;
    A = 4'b0001;
    B = 4'b0011;
    S = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_rot0", Out, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    chk("abort_rot1", Out, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", Out, 4'b0000);
    chk("abort_zero", Zero, 1'b1);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rel_ready", in_ready, 1'b1);
    chk("abort_rel_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("abort_no_deliver", out_valid, 1'b0);
    chk("abort_rel_out", Out, 4'b0000);

    if (ACC) begin
      run_op(4'b0011, 4'b0101, 3'd1, 0, 1'b0);
      run_op(W'($urandom), 4'b0010, 3'd2, 0, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
             ACC && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
